rob_alloc_ctrl: RTL and testbench



---
 rtl/uarch_pkg.sv | 24 ++
 rtl/rob_grant_logic.sv | 35 +++
 rtl/rob_alloc_ctrl.sv | 92 +++++++++
 tb/tb_rob_alloc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture sizing for the out-of-order core.
// Pipeline width, ROB geometry and small helpers used across stages.
package uarch_pkg;

   localparam int PIPE_WIDTH = 2;
   localparam int ROB_DEPTH  = 32;
   localparam int TAG_WIDTH  = $clog2(ROB_DEPTH);
   localparam int CNT_WIDTH  = TAG_WIDTH + 1;

   typedef logic [TAG_WIDTH-1:0] rob_tag_t;
   typedef logic [CNT_WIDTH-1:0] rob_cnt_t;

   function automatic rob_cnt_t popcnt(
      input logic [PIPE_WIDTH-1:0] v
   );
      rob_cnt_t n;
      n = '0;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         n = n + rob_cnt_t'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rob_grant_logic.sv
// Combinational ROB free-space check, in-order grant vector and tags.
// Slot i needs room for itself plus every requesting slot below it.
module rob_grant_logic
   import uarch_pkg::*;
(
   input  logic                                 i_flush,
   input  logic [PIPE_WIDTH-1:0]                i_req,
   input  rob_cnt_t                             i_count,
   input  rob_tag_t                             i_tail,
   output logic [PIPE_WIDTH-1:0]                o_gnt,
   output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] o_tags,
   output rob_cnt_t                             o_ngnt
);

   rob_cnt_t w_free;

   assign w_free = rob_cnt_t'(ROB_DEPTH) - i_count;

   always_comb begin
      rob_cnt_t w_need;
      w_need = '0;
      o_gnt  = '0;
      o_tags = '0;
      o_ngnt = '0;
      for (int i = 0; i < PIPE_WIDTH; i++) begin
         // tag skips only slots that actually request
         o_tags[i] = i_tail + w_need[TAG_WIDTH-1:0];
         w_need    = w_need + rob_cnt_t'(i_req[i]);
         o_gnt[i]  = i_req[i] && !i_flush
                     && (w_free >= w_need);
         o_ngnt    = o_ngnt + rob_cnt_t'(o_gnt[i]);
      end
   end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation control: head/tail/count bookkeeping and rename grants.
// Optional stall counter enabled by defining ROB_ALLOC_STATS_EN.
module rob_alloc_ctrl
   import uarch_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [PIPE_WIDTH-1:0]                alloc_req,
   input  logic                                 alloc_fire,
   output logic [PIPE_WIDTH-1:0]                alloc_gnt,
   output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] alloc_tags,
   input  logic [PIPE_WIDTH-1:0]                commit_valid,
   output logic [TAG_WIDTH-1:0]                 head_tag,
   output logic [TAG_WIDTH-1:0]                 tail_tag,
   output logic [TAG_WIDTH:0]                   count,
   output logic                                 full,
   output logic                                 empty,
   output logic [31:0]                          stall_cycles
);

   rob_tag_t r_head;
   rob_tag_t r_tail;
   rob_cnt_t r_count;

   rob_cnt_t w_ngnt;
   rob_cnt_t w_nalloc;
   rob_cnt_t w_ncommit_raw;
   rob_cnt_t w_ncommit;

   rob_grant_logic u_grant (
      .i_flush (flush),
      .i_req   (alloc_req),
      .i_count (r_count),
      .i_tail  (r_tail),
      .o_gnt   (alloc_gnt),
      .o_tags  (alloc_tags),
      .o_ngnt  (w_ngnt)
   );

   assign w_nalloc      = alloc_fire ? w_ngnt : '0;
   assign w_ncommit_raw = popcnt(commit_valid);
   // never retire more entries than are live
   assign w_ncommit     = (w_ncommit_raw > r_count)
                          ? r_count : w_ncommit_raw;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_tail  <= r_tail + w_nalloc[TAG_WIDTH-1:0];
         r_head  <= r_head + w_ncommit[TAG_WIDTH-1:0];
         r_count <= r_count + w_nalloc - w_ncommit;
      end
   end

   assign head_tag = r_head;
   assign tail_tag = r_tail;
   assign count    = r_count;
   assign full     = (r_count == rob_cnt_t'(ROB_DEPTH));
   assign empty    = (r_count == '0);

`ifdef ROB_ALLOC_STATS_EN
   logic [31:0] r_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
      end else if (!flush
                   && (alloc_req & ~alloc_gnt) != '0
                   && r_stall != '1) begin
         r_stall <= r_stall + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
`else
   assign stall_cycles = '0;
`endif

   a_fire_all_granted: assert property (
      @(posedge clk) disable iff (rst || flush)
      alloc_fire |-> ((alloc_req & ~alloc_gnt) == '0));

   a_commit_prefix: assert property (
      @(posedge clk) disable iff (rst)
      (commit_valid
       & (commit_valid + PIPE_WIDTH'(1))) == '0);

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: vector table, corner sequences, random vs model.
// Stall expectations follow ROB_ALLOC_STATS_EN.
module tb_rob_alloc_ctrl;
   import uarch_pkg::*;

   localparam int D = ROB_DEPTH;
`ifdef ROB_ALLOC_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic [1:0] alloc_req = '0;
   logic alloc_fire = 1'b0;
   logic [1:0] alloc_gnt;
   logic [1:0][TAG_WIDTH-1:0] alloc_tags;
   logic [1:0] commit_valid = '0;
   logic [TAG_WIDTH-1:0] head_tag;
   logic [TAG_WIDTH-1:0] tail_tag;
   logic [TAG_WIDTH:0] count;
   logic full;
   logic empty;
   logic [31:0] stall_cycles;

   always #5 clk = ~clk;

   rob_alloc_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .alloc_req    (alloc_req),
      .alloc_fire   (alloc_fire),
      .alloc_gnt    (alloc_gnt),
      .alloc_tags   (alloc_tags),
      .commit_valid (commit_valid),
      .head_tag     (head_tag),
      .tail_tag     (tail_tag),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .stall_cycles (stall_cycles)
   );

   int n_chk = 0;
   int n_fail = 0;

   // reference model: live-entry count and next tag
   int m_tail = 0;
   int m_cnt = 0;
   logic [31:0] m_stall = '0;
   logic [1:0] m_gnt;
   int m_t0, m_t1;

   logic [1:0] s_gnt;
   int s_t0, s_t1;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   function automatic int m_head();
      return ((m_tail - m_cnt) % D + D) % D;
   endfunction

   task automatic model_comb(input logic [1:0] rq, input logic fl,
                             output logic [1:0] g,
                             output int t0, output int t1);
      int free;
      int k;
      int t[2];
      free = D - m_cnt;
      k = 0;
      g = '0;
      for (int i = 0; i < 2; i++) begin
         t[i] = (m_tail + k) % D;
         if (rq[i]) begin
            k++;
            g[i] = !fl && (k <= free);
         end
      end
      t0 = t[0];
      t1 = t[1];
   endtask

   task automatic cyc(input logic [1:0] rq, input logic fi,
                      input logic [1:0] cv, input logic fl);
      int na;
      int nc;
      alloc_req = rq;
      alloc_fire = fi;
      commit_valid = cv;
      flush = fl;
      model_comb(rq, fl, m_gnt, m_t0, m_t1);
      @(negedge clk);
      s_gnt = alloc_gnt;
      s_t0 = int'(alloc_tags[0]);
      s_t1 = int'(alloc_tags[1]);
      @(posedge clk);
      na = fi ? $countones(m_gnt) : 0;
      nc = $countones(cv);
      if (nc > m_cnt) nc = m_cnt;
      if (STATS != 0) begin
         if (rst) m_stall = '0;
         else if (!fl && (rq & ~m_gnt) != 2'b00
                  && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 32'd1;
      end
      if (rst || fl) begin
         m_tail = 0;
         m_cnt = 0;
      end else begin
         m_tail = (m_tail + na) % D;
         m_cnt = m_cnt + na - nc;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2'b00, 1'b0, 2'b00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_gnt"}, s_gnt, m_gnt);
      if (m_gnt[0]) chk({tag, "_t0"}, s_t0, m_t0);
      if (m_gnt[1]) chk({tag, "_t1"}, s_t1, m_t1);
      chk({tag, "_cnt"}, count, m_cnt);
      chk({tag, "_head"}, head_tag, m_head());
      chk({tag, "_tail"}, tail_tag, m_tail);
      chk({tag, "_full"}, full, m_cnt == D);
      chk({tag, "_empty"}, empty, m_cnt == 0);
      chk({tag, "_stall"}, stall_cycles, m_stall);
   endtask

   typedef struct {
      logic [1:0] req;
      logic       fi;
      logic [1:0] cv;
      logic       fl;
      logic [1:0] gnt;
      int         t0;
      int         t1;
      int         cnt;
      int         hd;
      int         tl;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{2'b11, 1'b1, 2'b00, 1'b0, 2'b11, 0, 1, 2, 0, 2};
      tbl[1] = '{2'b01, 1'b1, 2'b00, 1'b0, 2'b01, 2, 3, 3, 0, 3};
      tbl[2] = '{2'b10, 1'b1, 2'b01, 1'b0, 2'b10, 3, 3, 3, 1, 4};
      tbl[3] = '{2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 4, 4, 1, 3, 4};
      tbl[4] = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b11, 4, 5, 1, 3, 4};
      tbl[5] = '{2'b11, 1'b0, 2'b11, 1'b0, 2'b11, 4, 5, 0, 4, 4};
      tbl[6] = '{2'b11, 1'b0, 2'b00, 1'b1, 2'b00, 4, 5, 0, 0, 0};
      tbl[7] = '{2'b11, 1'b1, 2'b00, 1'b0, 2'b11, 0, 1, 2, 0, 2};

      @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_gnt", alloc_gnt, 2'b00);
      chk("rst_cnt", count, 0);
      chk("rst_head", head_tag, 0);
      chk("rst_tail", tail_tag, 0);
      chk("rst_stall", stall_cycles, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].req, tbl[i].fi, tbl[i].cv, tbl[i].fl);
         chk($sformatf("vec%0d_gnt", i), s_gnt, tbl[i].gnt);
         chk($sformatf("vec%0d_t0", i), s_t0, tbl[i].t0);
         chk($sformatf("vec%0d_t1", i), s_t1, tbl[i].t1);
         chk($sformatf("vec%0d_cnt", i), count, tbl[i].cnt);
         chk($sformatf("vec%0d_head", i), head_tag, tbl[i].hd);
         chk($sformatf("vec%0d_tail", i), tail_tag, tbl[i].tl);
      end

      // fill to 31, partial grant, then full with commit
      do_reset();
      for (int i = 0; i < 15; i++) cyc(2'b11, 1'b1, 2'b00, 1'b0);
      cyc(2'b01, 1'b1, 2'b00, 1'b0);
      chk("fill31_cnt", count, 31);
      chk("fill31_full", full, 1'b0);
      cyc(2'b11, 1'b0, 2'b00, 1'b0);
      chk("part_gnt", s_gnt, 2'b01);
      chk("part_t0", s_t0, 31);
      chk("hold_cnt", count, 31);
      chk("hold_full", full, 1'b0);
      cyc(2'b01, 1'b1, 2'b00, 1'b0);
      chk("full_cnt", count, 32);
      chk("full_flag", full, 1'b1);
      cyc(2'b11, 1'b0, 2'b11, 1'b0);
      chk("fullc_gnt", s_gnt, 2'b00);
      chk("fullc_cnt", count, 30);
      chk("fullc_head", head_tag, 2);

      // tail wrap with empty ROB
      do_reset();
      for (int i = 0; i < 15; i++) cyc(2'b11, 1'b1, 2'b00, 1'b0);
      cyc(2'b01, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 15; i++) cyc(2'b00, 1'b0, 2'b11, 1'b0);
      cyc(2'b00, 1'b0, 2'b01, 1'b0);
      chk("wrap_pre_cnt", count, 0);
      chk("wrap_pre_tail", tail_tag, 31);
      cyc(2'b11, 1'b1, 2'b00, 1'b0);
      chk("wrap_gnt", s_gnt, 2'b11);
      chk("wrap_t0", s_t0, 31);
      chk("wrap_t1", s_t1, 0);
      chk("wrap_tail", tail_tag, 1);
      chk("wrap_cnt", count, 2);

      // flush with live entries
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'b11, 1'b1, 2'b00, 1'b0);
      cyc(2'b01, 1'b1, 2'b00, 1'b0);
      chk("fl_pre_cnt", count, 17);
      cyc(2'b11, 1'b0, 2'b00, 1'b1);
      chk("fl_gnt", s_gnt, 2'b00);
      chk("fl_cnt", count, 0);
      chk("fl_head", head_tag, 0);
      chk("fl_tail", tail_tag, 0);
      chk("fl_empty", empty, 1'b1);

      // stall counter: held full, survives flush, cleared by reset
      do_reset();
      for (int i = 0; i < 16; i++) cyc(2'b11, 1'b1, 2'b00, 1'b0);
      chk("st_full", full, 1'b1);
      for (int i = 0; i < 10; i++) cyc(2'b01, 1'b0, 2'b00, 1'b0);
      chk("st_10", stall_cycles, STATS != 0 ? 10 : 0);
      cyc(2'b00, 1'b0, 2'b00, 1'b1);
      chk("st_flush", stall_cycles, STATS != 0 ? 10 : 0);
      do_reset();
      chk("st_rst", stall_cycles, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] rq;
         logic [1:0] cv;
         logic [1:0] g;
         logic fi;
         logic fl;
         int t0, t1;
         int sel;
         bit fill;
         fill = ((i / 250) % 2) == 0;
         rq = 2'($urandom_range(0, 3));
         if (!fill && $urandom_range(0, 1) == 0) rq = 2'b00;
         sel = $urandom_range(0, 9);
         if (fill) cv = (sel < 7) ? 2'b00 : (sel < 9 ? 2'b01 : 2'b11);
         else cv = (sel < 2) ? 2'b00 : (sel < 5 ? 2'b01 : 2'b11);
         fl = ($urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 499) == 0);
         model_comb(rq, fl, g, t0, t1);
         fi = ((rq & ~g) == 2'b00) && ($urandom_range(0, 3) != 0)
              && !fl && !rst;
         cyc(rq, fi, cv, fl);
         rst = 1'b0;
         chk_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
